// File: rtl/pcs_scrambler_param_pkg.sv
// Shared constants and types for the x^58+x^39+1 self-synchronising scrambler.
package pcs_scrambler_param_pkg;

    localparam int unsigned LFSR_LEN = 58;
    localparam int unsigned TAP_A    = 38;
    localparam int unsigned TAP_B    = 57;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic {
        MODE_SCR   = 1'b0,
        MODE_DESCR = 1'b1
    } mode_e;

    // Anything other than a data or control sync pattern is a bad header.
    function automatic logic hdr_invalid(input logic [1:0] hdr);
        return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
    endfunction

endpackage

// File: rtl/pcs_scrambler_param_if.sv
// Payload/header stream with valid/ready on both the input and output side.
interface pcs_scrambler_param_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_header;
    logic                  in_data_valid;
    logic                  in_data_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_header;
    logic                  out_data_valid;
    logic                  out_data_ready;

    modport master (
        output in_data, in_header, in_data_valid, out_data_ready,
        input  in_data_ready, out_data, out_header, out_data_valid
    );

    modport slave (
        input  in_data, in_header, in_data_valid, out_data_ready,
        output in_data_ready, out_data, out_header, out_data_valid
    );
endinterface

// File: rtl/pcs_scrambler_param_core.sv
// Combinational one-word step of the scrambler: bit 0 first, serial recurrence unrolled.
module pcs_scrambler_param_core
    import pcs_scrambler_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [LFSR_LEN-1:0]   state,
    input  logic [DATA_WIDTH-1:0] data,
    input  mode_e                 mode,
    output logic [LFSR_LEN-1:0]   next_state,
    output logic [DATA_WIDTH-1:0] result
);

    logic [LFSR_LEN-1:0] s;
    logic                y;

    always_comb begin
        s      = state;
        y      = 1'b0;
        result = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            y         = data[i] ^ s[TAP_A] ^ s[TAP_B];
            result[i] = y;
            // Both directions shift in the line-side bit so mode can change freely.
            s = {s[LFSR_LEN-2:0], (mode == MODE_DESCR) ? data[i] : y};
        end
        next_state = s;
    end

endmodule

// File: rtl/pcs_scrambler_param.sv
// 64b/66b scrambler/descrambler with handshake register, bypass and programmable seed.
// Optional invalid-header counter enabled by PCS_SCRAMBLER_HDR_ERR_CNT_EN.
module pcs_scrambler_param
    import pcs_scrambler_param_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 64,
    parameter logic [LFSR_LEN-1:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  bypass,
    pcs_scrambler_param_if.slave  bus,
    output logic [15:0]           hdr_err_cnt
);

    logic [LFSR_LEN-1:0]   lfsr_q;
    logic [LFSR_LEN-1:0]   lfsr_next;
    logic [DATA_WIDTH-1:0] core_result;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            header_q;
    logic                  valid_q;
    logic                  accept;

    pcs_scrambler_param_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .state      (lfsr_q),
        .data       (bus.in_data),
        .mode       (mode_e'(mode)),
        .next_state (lfsr_next),
        .result     (core_result)
    );

    assign bus.in_data_ready  = !valid_q || bus.out_data_ready;
    assign accept             = bus.in_data_valid && bus.in_data_ready;
    assign bus.out_data       = data_q;
    assign bus.out_header     = header_q;
    assign bus.out_data_valid = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q   <= SEED;
            data_q   <= '0;
            header_q <= '0;
            valid_q  <= 1'b0;
        end else if (accept) begin
            data_q   <= bypass ? bus.in_data : core_result;
            header_q <= bus.in_header;
            valid_q  <= 1'b1;
            if (!bypass) begin
                lfsr_q <= lfsr_next;
            end
        end else if (bus.out_data_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PCS_SCRAMBLER_HDR_ERR_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept && hdr_invalid(bus.in_header) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign hdr_err_cnt = cnt_q;
`else
    assign hdr_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pcs_scrambler_param.sv
// Scoreboard bench: driver pushes model results, monitor pops on each output transfer.
module tb_pcs_scrambler_param;

    localparam int unsigned W = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        bypass = 1'b0;
    logic [15:0] cnt;

    pcs_scrambler_param_if #(.DATA_WIDTH(W)) bus ();

    pcs_scrambler_param #(
        .DATA_WIDTH (W),
        .SEED       (58'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .bypass      (bypass),
        .bus         (bus),
        .hdr_err_cnt (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   hdr;
        logic [15:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    bit          hist[$];   // line bits, oldest first
    logic [15:0] exp_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          bp_mode = 0;  // 0 ready, 1 random, 2 stalled

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 58; i++) hist.push_back(1'b0);
        exp_cnt = 16'h0;
    endfunction

    // Line bit n = d ^ line[n-39] ^ line[n-58]; descrambler feeds the received line bit back.
    function automatic logic [W-1:0] model_beat(input logic [W-1:0] d, input bit m, input bit byp);
        logic [W-1:0] r;
        bit           y;
        if (byp) return d;
        for (int i = 0; i < W; i++) begin
            y    = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
            r[i] = y;
            hist.push_back(m ? d[i] : y);
            void'(hist.pop_front());
        end
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [1:0] h, input bit m, input bit byp,
                        input bit ovr, input logic [W-1:0] ovr_d, output logic [W-1:0] res);
        exp_t e;
        int   waited;
        bus.in_data       = d;
        bus.in_header     = h;
        bus.in_data_valid = 1'b1;
        mode              = m;
        bypass            = byp;
        waited            = 0;
        @(negedge clk);
        while (!bus.in_data_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        res = '0;
        if (!bus.in_data_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got ready=0 required ready=1");
        end else begin
            res = model_beat(d, m, byp);
`ifdef PCS_SCRAMBLER_HDR_ERR_CNT_EN
            if ((h == 2'b00 || h == 2'b11) && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
            e.data = ovr ? ovr_d : res;
            e.hdr  = h;
            e.cnt  = exp_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        int waited = 0;
        bus.in_data_valid = 1'b0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        check("drain_queue_empty", W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       bus.out_data_ready = 1'b1;
            1:       bus.out_data_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_data_ready = 1'b0;
        endcase
    end

    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_hdr;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_data", bus.out_data, prev_data);
                check("hold_header", W'(bus.out_header), W'(prev_hdr));
                check("hold_valid", W'(bus.out_data_valid), W'(1));
            end
            if (bus.out_data_valid && !bus.out_data_ready)
                check("stall_in_ready", W'(bus.in_data_ready), W'(0));
            if (bus.out_data_valid && bus.out_data_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got data %h required no beat", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_e.data);
                    check("out_header", W'(bus.out_header), W'(mon_e.hdr));
                    check("hdr_err_cnt", W'(cnt), W'(mon_e.cnt));
                end
            end
            hold_prev = bus.out_data_valid && !bus.out_data_ready;
            prev_data = bus.out_data;
            prev_hdr  = bus.out_header;
        end
    end

    logic [W-1:0] p[10];
    logic [W-1:0] l[10];
    logic [W-1:0] res;
    logic [W-1:0] err_mask;
    logic [W-1:0] flip;

    initial begin
        bus.in_data        = '0;
        bus.in_header      = 2'b01;
        bus.in_data_valid  = 1'b0;
        bus.out_data_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(bus.out_data_valid), W'(0));
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_header", W'(bus.out_header), W'(0));
        check("rst_hdr_err_cnt", W'(cnt), W'(0));
        check("rst_in_ready", W'(bus.in_data_ready), W'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Zero state stays zero.
        for (int k = 0; k < 5; k++) send('0, 2'b01, 1'b0, 1'b0, 1'b1, '0, res);
        idle_drain();

        // Loopback: scramble, then descramble the model's line words back to the plaintext.
        do_reset();
        p[0] = 64'h78d5555555555555;
        for (int k = 1; k < 10; k++) p[k] = {$urandom, $urandom};
        for (int k = 0; k < 10; k++) send(p[k], 2'b10, 1'b0, 1'b0, 1'b0, '0, l[k]);
        idle_drain();
        do_reset();
        for (int k = 0; k < 10; k++) send(l[k], 2'b10, 1'b1, 1'b0, 1'b1, p[k], res);
        idle_drain();

        // Error multiplication: one flipped line bit hits output bits 5, 44, 63 of the same word.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            p[k] = {$urandom, $urandom};
            l[k] = model_beat(p[k], 1'b0, 1'b0);
        end
        model_reset();
        flip     = 64'd1 << 5;
        err_mask = (64'd1 << 5) | (64'd1 << 44) | (64'd1 << 63);
        for (int k = 0; k < 6; k++)
            send((k == 2) ? (l[k] ^ flip) : l[k], 2'b01, 1'b1, 1'b0, 1'b1,
                 (k == 2) ? (p[k] ^ err_mask) : p[k], res);
        idle_drain();

        // Random traffic with random backpressure, mode and bypass.
        do_reset();
        bp_mode = 1;
        for (int k = 0; k < 300; k++)
            send({$urandom, $urandom}, 2'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                 1'b0, '0, res);
        bp_mode = 0;
        idle_drain();

        // Explicit stall mid-stream.
        for (int k = 0; k < 2; k++) send({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 1'b0, '0, res);
        bp_mode = 2;
        fork
            begin
                repeat (4) @(posedge clk);
                bp_mode = 0;
            end
        join_none
        for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 1'b0, '0, res);
        idle_drain();

        // Bypass two beats, then resume scrambling on the frozen LFSR.
        for (int k = 0; k < 5; k++) begin
            flip = {$urandom, $urandom};
            send(flip, 2'b01, 1'b0, (k == 1 || k == 2), (k == 1 || k == 2), flip, res);
        end
        idle_drain();

        // Header counter.
        do_reset();
        send({$urandom, $urandom}, 2'b00, 1'b0, 1'b0, 1'b0, '0, res);
        send({$urandom, $urandom}, 2'b11, 1'b0, 1'b1, 1'b0, '0, res);
        send({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, 1'b0, '0, res);
        idle_drain();
`ifdef PCS_SCRAMBLER_HDR_ERR_CNT_EN
        check("hdr_cnt_total", W'(cnt), W'(2));
`else
        check("hdr_cnt_total", W'(cnt), W'(0));
`endif

        // Reset while a beat is held at the output.
        bp_mode = 2;
        send({$urandom, $urandom}, 2'b11, 1'b0, 1'b0, 1'b0, '0, res);
        bus.in_data_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", W'(bus.out_data_valid), W'(0));
        check("midrst_out_data", bus.out_data, '0);
        check("midrst_out_header", W'(bus.out_header), W'(0));
        check("midrst_hdr_err_cnt", W'(cnt), W'(0));
        bp_mode = 0;
        do_reset();
        for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 2'b10, 1'b0, 1'b0, 1'b0, '0, res);
        idle_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
